// File: rtl/packet_grant_mux_pkg.sv
// Shared types and helpers for the packet grant mux: FSM state encoding and
// the one-hot legality check applied to the arbiter grant.
package pgm_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } pgm_state_t;

  // Widest grant vector the legality check accepts; callers zero-extend.
  localparam int PGM_MAX_W = 32;

  function automatic logic is_onehot(input logic [PGM_MAX_W-1:0] vec);
    return (vec != '0) && ((vec & (vec - PGM_MAX_W'(1))) == '0);
  endfunction

endpackage

// File: rtl/onehot_data_mux.sv
// AND-OR selector: returns the lane picked by a one-hot select, or zero when
// the select is empty.
module onehot_data_mux #(
  parameter int NUM_PORTS = 4,
  parameter int WIDTH     = 9
) (
  input  logic [NUM_PORTS-1:0]       sel,
  input  logic [NUM_PORTS*WIDTH-1:0] data,
  output logic [WIDTH-1:0]           y
);

  always_comb begin
    y = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      y = y | (data[k*WIDTH +: WIDTH] & {WIDTH{sel[k]}});
    end
  end

endmodule

// File: rtl/packet_grant_mux.sv
// Locks the arbiter's one-hot grant for a whole packet and forwards the owner's
// beats through a single registered valid/ready output stage.
module packet_grant_mux
  import pgm_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_PORTS-1:0]        req_i,
  input  logic [NUM_PORTS*DATA_W-1:0] data_i,
  input  logic [NUM_PORTS-1:0]        last_i,
  input  logic [NUM_PORTS-1:0]        gnt_i,
  output logic [NUM_PORTS-1:0]        ready_o,
  output logic                        out_valid_o,
  output logic [DATA_W-1:0]           out_data_o,
  output logic                        out_last_o,
  input  logic                        out_ready_i,
  output logic [NUM_PORTS-1:0]        owner_o,
  output logic                        busy_o
);

  localparam int BEAT_W = DATA_W + 1;

  // Handshake: a beat moves from port k when req_i[k] & ready_o[k] are both
  // high at a rising edge; the output beat moves when out_valid_o &
  // out_ready_i are both high. Once raised, out_valid_o and its payload stay
  // put until the downstream takes them.

  pgm_state_t                  state;
  logic                        can_load;
  logic                        accept;
  logic                        gnt_legal;
  logic [NUM_PORTS*BEAT_W-1:0] beat_bus;
  logic [BEAT_W-1:0]           sel_beat;

  always_comb begin
    beat_bus = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      beat_bus[k*BEAT_W +: BEAT_W] = {last_i[k], data_i[k*DATA_W +: DATA_W]};
    end
  end

  onehot_data_mux #(
    .NUM_PORTS (NUM_PORTS),
    .WIDTH     (BEAT_W)
  ) u_beat_mux (
    .sel  (owner_o),
    .data (beat_bus),
    .y    (sel_beat)
  );

  assign can_load  = ~out_valid_o | out_ready_i;
  assign ready_o   = (state == LOCKED) ? (owner_o & {NUM_PORTS{can_load}}) : '0;
  assign accept    = |(req_i & ready_o);
  assign busy_o    = (state == LOCKED);
  assign gnt_legal = is_onehot(PGM_MAX_W'(gnt_i));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner_o     <= '0;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_last_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // A lock may be taken while the previous packet's tail still sits
          // in the output register; ready_o waits on can_load.
          if (gnt_legal) begin
            owner_o <= gnt_i;
            state   <= LOCKED;
          end
        end
        LOCKED: begin
          if (accept && sel_beat[DATA_W]) begin
            owner_o <= '0;
            state   <= IDLE;
          end
        end
        default: begin
          owner_o <= '0;
          state   <= IDLE;
        end
      endcase

      if (accept) begin
        out_valid_o <= 1'b1;
        out_data_o  <= sel_beat[DATA_W-1:0];
        out_last_o  <= sel_beat[DATA_W];
      end else if (out_valid_o && out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_packet_grant_mux.sv
// Randomized and directed stimulus for packet_grant_mux, checked against a
// packet-level reference model with per-port beat queues.
module tb_packet_grant_mux;

  localparam int NP = 4;
  localparam int DW = 8;

  logic            clk;
  logic            reset_n;
  logic [NP-1:0]   req_i;
  logic [NP*DW-1:0] data_i;
  logic [NP-1:0]   last_i;
  logic [NP-1:0]   gnt_i;
  logic [NP-1:0]   ready_o;
  logic            out_valid_o;
  logic [DW-1:0]   out_data_o;
  logic            out_last_o;
  logic            out_ready_i;
  logic [NP-1:0]   owner_o;
  logic            busy_o;

  packet_grant_mux #(.NUM_PORTS(NP), .DATA_W(DW)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_i       (req_i),
    .data_i      (data_i),
    .last_i      (last_i),
    .gnt_i       (gnt_i),
    .ready_o     (ready_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_last_o  (out_last_o),
    .out_ready_i (out_ready_i),
    .owner_o     (owner_o),
    .busy_o      (busy_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Source queues: one entry per pending beat, {last, data}
  logic [DW:0]   src_q [NP][$];
  logic [DW:0]   exp_q [$];

  // Reference model: owner index (-1 = no lock) and the output slot
  int            m_owner;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;

  // Stimulus controls
  logic          rst_drv;
  logic          ordy;
  logic [NP-1:0] en;
  logic          force_en;
  logic [NP-1:0] force_gnt;
  logic          checks_on;

  int n_vec;
  int n_err;

  function automatic logic [NP-1:0] oh(input int idx);
    return (idx < 0) ? '0 : NP'(1 << idx);
  endfunction

  // Fixed-priority arbiter stand-in: port 0 wins
  function automatic logic [NP-1:0] prio(input logic [NP-1:0] r);
    for (int k = 0; k < NP; k++) if (r[k]) return oh(k);
    return '0;
  endfunction

  function automatic int idx_of(input logic [NP-1:0] v);
    for (int k = 0; k < NP; k++) if (v[k]) return k;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_beat(input int p, input logic [DW-1:0] d, input logic l);
    src_q[p].push_back({l, d});
  endtask

  task automatic push_rand_pkt(input int p, input int len);
    for (int i = 0; i < len; i++) push_beat(p, DW'($urandom_range(0, 255)), i == len - 1);
  endtask

  // One clock cycle: entered and left just after a falling edge.
  task automatic cycle();
    logic [NP-1:0] m_rdy;
    logic          m_acc;
    logic [DW:0]   beat;
    logic [DW:0]   e;
    if (checks_on) begin
      check("out_valid", 32'(out_valid_o), 32'(m_valid));
      check("out_data",  32'(out_data_o),  32'(m_data));
      check("out_last",  32'(out_last_o),  32'(m_last));
      check("owner",     32'(owner_o),     32'(oh(m_owner)));
      check("busy",      32'(busy_o),      32'(m_owner >= 0));
    end
    for (int k = 0; k < NP; k++) begin
      req_i[k] = en[k] && (src_q[k].size() > 0);
      beat = (src_q[k].size() > 0) ? src_q[k][0] : (DW+1)'($urandom_range(0, 511));
      data_i[k*DW +: DW] = beat[DW-1:0];
      last_i[k] = beat[DW];
    end
    gnt_i       = force_en ? force_gnt : prio(req_i);
    out_ready_i = ordy;
    reset_n     = rst_drv;
    #1;
    m_rdy = (m_owner >= 0 && (!m_valid || ordy)) ? oh(m_owner) : '0;
    if (checks_on) begin
      check("ready", 32'(ready_o), 32'(m_rdy));
      if (rst_drv && out_valid_o === 1'b1 && ordy) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("sb_beat", 32'({out_last_o, out_data_o}), 32'(e));
        end
      end
    end
    m_acc = rst_drv && ((m_rdy & req_i) != '0);
    @(posedge clk);
    if (!rst_drv) begin
      m_owner = -1;
      m_valid = 1'b0;
      m_data  = '0;
      m_last  = 1'b0;
      for (int k = 0; k < NP; k++) src_q[k].delete();
      exp_q.delete();
    end else begin
      if (m_valid && ordy && !m_acc) m_valid = 1'b0;
      if (m_acc) begin
        beat    = src_q[m_owner].pop_front();
        m_valid = 1'b1;
        m_data  = beat[DW-1:0];
        m_last  = beat[DW];
        exp_q.push_back(beat);
        if (beat[DW]) m_owner = -1;
      end else if (m_owner < 0 && $countones(gnt_i) == 1) begin
        m_owner = idx_of(gnt_i);
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int  guard;
    logic pending;
    n_vec = 0; n_err = 0;
    m_owner = -1; m_valid = 1'b0; m_data = '0; m_last = 1'b0;
    rst_drv = 1'b0; ordy = 1'b1; en = '1; force_en = 1'b0; force_gnt = '0;
    checks_on = 1'b0;
    req_i = '0; data_i = '0; last_i = '0; gnt_i = '0; out_ready_i = 1'b1; reset_n = 1'b0;

    @(negedge clk);
    cycle();
    checks_on = 1'b1;
    cycle();
    rst_drv = 1'b1;
    check("rst_owner", 32'(owner_o), 32'd0);
    check("rst_valid", 32'(out_valid_o), 32'd0);
    check("rst_busy",  32'(busy_o), 32'd0);

    // 1: three-beat packet on port 2
    push_beat(2, 8'hA1, 1'b0);
    push_beat(2, 8'hA2, 1'b0);
    push_beat(2, 8'hA3, 1'b1);
    cycle();
    check("t1_owner", 32'(owner_o), 32'h4);
    cycle();
    check("t1_first", 32'(out_data_o), 32'hA1);
    run(4);

    // 2: ports 1 and 3 request together
    push_rand_pkt(1, 2);
    push_rand_pkt(3, 2);
    run(10);

    // 3: backpressure after the first beat
    push_beat(2, 8'h31, 1'b0);
    push_beat(2, 8'h32, 1'b1);
    cycle();
    cycle();
    ordy = 1'b0;
    run(4);
    check("t3_frozen", 32'(out_data_o), 32'h31);
    check("t3_ready",  32'(ready_o), 32'h0);
    ordy = 1'b1;
    cycle();
    check("t3_next", 32'(out_data_o), 32'h32);
    run(3);

    // 4: higher-priority port arrives mid-packet
    push_rand_pkt(1, 3);
    cycle();
    cycle();
    push_rand_pkt(0, 2);
    cycle();
    check("t4_hold", 32'(owner_o), 32'h2);
    run(8);

    // 5: reset during beat 2 of a 4-beat packet
    push_rand_pkt(0, 4);
    cycle();
    cycle();
    rst_drv = 1'b0;
    cycle();
    rst_drv = 1'b1;
    check("t5_valid", 32'(out_valid_o), 32'd0);
    check("t5_owner", 32'(owner_o), 32'd0);
    check("t5_busy",  32'(busy_o), 32'd0);
    push_rand_pkt(3, 2);
    run(6);

    // 6: illegal multi-hot grant in IDLE
    force_en = 1'b1;
    force_gnt = 4'b0011;
    run(3);
    check("t6_owner", 32'(owner_o), 32'd0);
    check("t6_busy",  32'(busy_o), 32'd0);
    force_en = 1'b0;

    // Randomized traffic with stalls on both sides
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NP; k++) begin
        if (src_q[k].size() == 0 && $urandom_range(0, 7) == 0)
          push_rand_pkt(k, int'($urandom_range(1, 4)));
        en[k] = ($urandom_range(0, 9) != 0);
      end
      ordy = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Drain everything, bounded
    en = '1;
    ordy = 1'b1;
    guard = 0;
    pending = 1'b1;
    while (pending && guard < 300) begin
      pending = (m_owner >= 0) || m_valid;
      for (int k = 0; k < NP; k++) if (src_q[k].size() > 0) pending = 1'b1;
      if (pending) cycle();
      guard++;
    end
    check("drain_done", 32'(pending), 32'd0);
    check("sb_left", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
